// File: rtl/serial_sub_nbit.sv
// serial_sub_nbit: bit-serial N-bit subtractor.
// Computes diff = a - b - bin one bit per clock, LSB first. A single
// full-subtractor cell feeds a borrow flip-flop. Operands are captured on an
// accepted start. The result is registered and held until the next operation
// completes.
module serial_sub_nbit #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_d_sh;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_accept;
    logic             w_d;
    logic             w_brw_next;
    logic [WIDTH-1:0] w_d_sh_next;

    // Start is only honoured between operations. In DONE it is honoured too,
    // so back-to-back operations need no idle cycle.
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Full-subtractor cell working on the current LSBs.
    assign w_d        = r_a_sh[0] ^ r_b_sh[0] ^ r_brw;
    assign w_brw_next = (~r_a_sh[0] & r_b_sh[0]) | (~(r_a_sh[0] ^ r_b_sh[0]) & r_brw);

    // Difference bits enter at the MSB, so the LSB-first result lands in
    // place after WIDTH steps. A 1-bit result has nothing to shift down.
    generate
        if (WIDTH == 1) begin : g_dsh_one
            assign w_d_sh_next = w_d;
        end else begin : g_dsh_many
            assign w_d_sh_next = {w_d, r_d_sh[WIDTH-1:1]};
        end
    endgenerate

    // Control FSM and serial datapath. The result registers load only on
    // the final step.
    always_ff @(posedge clk) begin
        // NOTE: every state register uses <= so all updates see pre-edge values.
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_d_sh  <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_brw   <= bin;
                        r_d_sh  <= '0;
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    r_a_sh <= r_a_sh >> 1;
                    r_b_sh <= r_b_sh >> 1;
                    r_d_sh <= w_d_sh_next;
                    r_brw  <= w_brw_next;
                    r_cnt  <= r_cnt + CW'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_diff  <= w_d_sh_next;
                        r_bout  <= w_brw_next;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (r_state == S_SHIFT);
    assign done = (r_state == S_DONE);
    assign diff = r_diff;
    assign bout = r_bout;

endmodule

// File: tb/tb_serial_sub_nbit.sv
// Testbench for serial_sub_nbit (WIDTH = 3).
// The reference model is plain wide subtraction: {bout,diff} = {0,a} - b - bin.
module tb_serial_sub_nbit;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W:0]   last_res;

    serial_sub_nbit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    // Behavioural reference: the borrow-out is bit W of the widened difference.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mbin);
        return {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One operation. The inputs are scrambled right after capture. The
    // latency, the busy length, the held result and the final result are
    // all checked.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
        logic [W:0] exp;
        int nb;
        int cyc;
        exp = model(ta, tb, tbin);
        @(negedge clk);
        a = ta; b = tb; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        nb = 0;
        cyc = 0;
        while (!done && cyc < 4 * W + 8) begin
            if (busy) nb++;
            check("hold_during_op", {bout, diff}, last_res);
            @(negedge clk);
            cyc++;
        end
        check("done_seen", done, 1);
        check("busy_cycles", nb, W);
        check("latency", cyc, W);
        check("busy_in_done", busy, 0);
        check("result", {bout, diff}, exp);
        last_res = exp;
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ba[3];
        logic [W-1:0] bb[3];
        logic         bbin[3];
        logic [W:0]   exp;
        int           k;
        int           prev_t;
        int           ndone;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        last_res = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", bout, 0);
        rst = 1'b0;

        // Directed cases.
        do_op(3'd5, 3'd3, 1'b0);
        do_op(3'd2, 3'd5, 1'b0);
        do_op(3'd0, 3'd0, 1'b1);
        do_op(3'd7, 3'd7, 1'b0);

        // Exhaustive sweep of every operand combination.
        for (int i = 0; i < (1 << W); i++)
            for (int j = 0; j < (1 << W); j++)
                for (int c = 0; c < 2; c++)
                    do_op(W'(i), W'(j), 1'(c));

        // A start during SHIFT is ignored: there is one done pulse and the
        // result belongs to the first operands.
        exp = model(3'd6, 3'd2, 1'b1);
        @(negedge clk);
        a = 3'd6; b = 3'd2; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 3'd1; b = 3'd7; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) begin
                ndone++;
                check("ignore_result", {bout, diff}, exp);
            end
            @(negedge clk);
        end
        check("ignore_pulses", ndone, 1);
        check("ignore_idle", busy, 0);
        last_res = exp;

        // Reset in the second SHIFT cycle aborts the operation with no done
        // pulse. The operands are chosen so the held result is nonzero first.
        do_op(3'd6, 3'd1, 1'b0);
        @(negedge clk);
        a = 3'd4; b = 3'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_bout", bout, 0);
        ndone = 0;
        for (int c = 0; c < 6; c++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("abort_quiet", ndone, 0);
        last_res = '0;

        // Start held high gives back-to-back operations, one every W+1 cycles.
        for (int i = 0; i < 3; i++) begin
            ba[i] = W'($urandom); bb[i] = W'($urandom); bbin[i] = 1'($urandom);
        end
        @(negedge clk);
        a = ba[0]; b = bb[0]; bin = bbin[0]; start = 1'b1;
        k = 0;
        prev_t = -1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done) begin
                if (k < 3) check("b2b_result", {bout, diff}, model(ba[k], bb[k], bbin[k]));
                if (prev_t >= 0) check("b2b_period", c - prev_t, W + 1);
                prev_t = c;
                k++;
                if (k < 3) begin
                    a = ba[k]; b = bb[k]; bin = bbin[k];
                end else begin
                    start = 1'b0;
                end
            end else if (k < 3) begin
                check("b2b_busy", busy, 1);
            end
        end
        check("b2b_count", k, 3);
        last_res = model(ba[2], bb[2], bbin[2]);
        repeat (2) @(negedge clk);
        check("b2b_hold", {bout, diff}, last_res);

        // Random operations.
        for (int i = 0; i < 20; i++)
            do_op(W'($urandom), W'($urandom), 1'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
